// File: rtl/proc_pkg.sv
// Shared processor-core constants: PC width, run sequencer states and per-program start addresses.
package proc_pkg;

  localparam int D = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } run_state_t;

  // Entry points of the four resident programs in instruction memory.
  localparam logic [D-1:0] PROG_START [4] = '{12'h000, 12'h040, 12'h100, 12'h280};

endpackage

// File: rtl/run_ctrl_cyc_counter.sv
// Clearable, enabled up-counter that holds at all-ones instead of wrapping.
module cyc_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: holds the core in reset, releases it at the selected program's start PC,
// counts run cycles until done or timeout, and hands dat_mem to the host outside a run.
module run_ctrl #(
  parameter int D       = proc_pkg::D,
  parameter int CW      = 16,
  parameter int RST_CYC = 2,
  parameter int MAX_CYC = 4000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [1:0]    prog_sel,
  input  logic          core_done,
  output logic          core_reset,
  output logic [D-1:0]  start_pc,
  input  logic          host_mem_req,
  output logic          host_gnt,
  output logic          mem_sel_core,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  import proc_pkg::*;

  localparam int            RW       = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [CW-1:0] LAST_CYC = CW'(MAX_CYC - 1);

  run_state_t    state_reg, state_next;
  logic [RW-1:0] clr_cnt_reg;
  logic [D-1:0]  start_pc_reg;
  logic          capture;
  logic          cnt_last;
  logic          cnt_en;

  // A pending host transfer takes precedence over starting a new run.
  assign capture  = (state_reg == IDLE) && req && !host_mem_req;
  assign cnt_last = (cycle_cnt == LAST_CYC);
  assign cnt_en   = (state_reg == RUN) && !core_done && !cnt_last;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (capture) state_next = CLEAR;
      CLEAR:   if (clr_cnt_reg == '0) state_next = RUN;
      RUN: begin
        if (core_done)     state_next = DONE;
        else if (cnt_last) state_next = TIMEOUT;
      end
      DONE,
      TIMEOUT: if (!req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      clr_cnt_reg  <= '0;
      start_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        start_pc_reg <= D'(PROG_START[prog_sel]);
        clr_cnt_reg  <= RW'(RST_CYC - 1);
      end else if ((state_reg == CLEAR) && (clr_cnt_reg != '0)) begin
        clr_cnt_reg <= clr_cnt_reg - RW'(1);
      end
    end
  end

  cyc_counter #(
    .CW (CW)
  ) u_cyc_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (capture),
    .en    (cnt_en),
    .cnt   (cycle_cnt)
  );

  assign core_reset   = (state_reg != RUN);
  assign mem_sel_core = (state_reg == CLEAR) || (state_reg == RUN);
  assign busy         = mem_sel_core;
  assign done         = (state_reg == DONE);
  assign timeout      = (state_reg == TIMEOUT);
  assign start_pc     = start_pc_reg;
  assign host_gnt     = host_mem_req & ~mem_sel_core;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: three instances (default, MAX_CYC=20, CW=4/MAX_CYC=15) driven in lockstep.
module tb_run_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic [1:0] prog_sel = 2'd0;
  logic       core_done = 1'b0;
  logic       host_mem_req = 1'b0;

  logic        core_reset_a, host_gnt_a, mem_sel_core_a, busy_a, done_a, timeout_a;
  logic [11:0] start_pc_a;
  logic [15:0] cycle_cnt_a;
  logic        core_reset_b, host_gnt_b, mem_sel_core_b, busy_b, done_b, timeout_b;
  logic [11:0] start_pc_b;
  logic [15:0] cycle_cnt_b;
  logic        core_reset_c, host_gnt_c, mem_sel_core_c, busy_c, done_c, timeout_c;
  logic [11:0] start_pc_c;
  logic [3:0]  cycle_cnt_c;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] prog_tab [4] = '{12'h000, 12'h040, 12'h100, 12'h280};

  always #5 clk = ~clk;

  run_ctrl #(.D(12), .CW(16), .RST_CYC(2), .MAX_CYC(4000)) dut_a (
    .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .core_done(core_done),
    .core_reset(core_reset_a), .start_pc(start_pc_a), .host_mem_req(host_mem_req),
    .host_gnt(host_gnt_a), .mem_sel_core(mem_sel_core_a), .busy(busy_a), .done(done_a),
    .timeout(timeout_a), .cycle_cnt(cycle_cnt_a));

  run_ctrl #(.D(12), .CW(16), .RST_CYC(2), .MAX_CYC(20)) dut_b (
    .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .core_done(core_done),
    .core_reset(core_reset_b), .start_pc(start_pc_b), .host_mem_req(host_mem_req),
    .host_gnt(host_gnt_b), .mem_sel_core(mem_sel_core_b), .busy(busy_b), .done(done_b),
    .timeout(timeout_b), .cycle_cnt(cycle_cnt_b));

  run_ctrl #(.D(12), .CW(4), .RST_CYC(2), .MAX_CYC(15)) dut_c (
    .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .core_done(core_done),
    .core_reset(core_reset_c), .start_pc(start_pc_c), .host_mem_req(host_mem_req),
    .host_gnt(host_gnt_c), .mem_sel_core(mem_sel_core_c), .busy(busy_c), .done(done_c),
    .timeout(timeout_c), .cycle_cnt(cycle_cnt_c));

  // A run with core_done raised at RUN cycle t ends with done if t fits under the
  // limit, otherwise with timeout after MAX_CYC run cycles; the count never exceeds limit.
  function automatic int sat(input int k, input int lim);
    return (k < lim) ? k : lim;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b0; host_mem_req = 1'b1; core_done = 1'b0;
    step(); step();
    n_checks++; if (core_reset_a !== 1'b1) $display("FAIL reset core_reset: got %b want 1", core_reset_a); else n_pass++;
    n_checks++; if (start_pc_a !== 12'h000) $display("FAIL reset start_pc: got %h want 000", start_pc_a); else n_pass++;
    n_checks++; if (mem_sel_core_a !== 1'b0) $display("FAIL reset mem_sel_core: got %b want 0", mem_sel_core_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL reset busy: got %b want 0", busy_a); else n_pass++;
    n_checks++; if (done_a !== 1'b0 || timeout_a !== 1'b0) $display("FAIL reset flags: got %b%b want 00", done_a, timeout_a); else n_pass++;
    n_checks++; if (cycle_cnt_a !== 16'd0) $display("FAIL reset cycle_cnt: got %0d want 0", cycle_cnt_a); else n_pass++;
    n_checks++; if (host_gnt_a !== 1'b1) $display("FAIL reset host_gnt: got %b want 1", host_gnt_a); else n_pass++;
    reset = 1'b1;
    host_mem_req = 1'b0;
    step();
    $display("reset: released, all instances idle");
  endtask

  task automatic do_run(input string name, input int sel, input int t, input int hold, input bit drop_req);
    logic [11:0] exp_pc;
    exp_pc = prog_tab[sel];
    prog_sel = 2'(sel); req = 1'b1; core_done = 1'b0;
    host_mem_req = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      step();
      n_checks++; if (busy_a !== 1'b0 || core_reset_a !== 1'b1) $display("FAIL %s idle_hold: busy=%b core_reset=%b want 0/1", name, busy_a, core_reset_a); else n_pass++;
      n_checks++; if (host_gnt_a !== 1'b1) $display("FAIL %s idle_gnt: got %b want 1", name, host_gnt_a); else n_pass++;
    end
    host_mem_req = 1'b0;
    step();
    n_checks++; if (busy_a !== 1'b1 || mem_sel_core_a !== 1'b1) $display("FAIL %s clear_entry: busy=%b mem_sel=%b want 1/1", name, busy_a, mem_sel_core_a); else n_pass++;
    n_checks++; if (start_pc_a !== exp_pc) $display("FAIL %s start_pc: got %h want %h", name, start_pc_a, exp_pc); else n_pass++;
    n_checks++; if (cycle_cnt_a !== 16'd0) $display("FAIL %s cnt_clear: got %0d want 0", name, cycle_cnt_a); else n_pass++;
    prog_sel = 2'($urandom);
    host_mem_req = 1'b1;
    #1;
    n_checks++; if (host_gnt_a !== 1'b0) $display("FAIL %s clear_gnt: got %b want 0", name, host_gnt_a); else n_pass++;
    step();
    n_checks++; if (core_reset_a !== 1'b1) $display("FAIL %s clear_hold: core_reset got %b want 1", name, core_reset_a); else n_pass++;
    step();
    n_checks++; if (core_reset_a !== 1'b0) $display("FAIL %s release_latency: core_reset got %b want 0", name, core_reset_a); else n_pass++;
    n_checks++; if (start_pc_a !== exp_pc || start_pc_c !== exp_pc) $display("FAIL %s start_pc_stable: got %h/%h want %h", name, start_pc_a, start_pc_c, exp_pc); else n_pass++;
    if (drop_req) req = 1'b0;
    for (int k = 0; k < t; k++) begin
      n_checks++; if (cycle_cnt_a !== 16'(k)) $display("FAIL %s run_cnt_a: got %0d want %0d", name, cycle_cnt_a, k); else n_pass++;
      n_checks++; if (cycle_cnt_b !== 16'(sat(k, 19))) $display("FAIL %s run_cnt_b: got %0d want %0d", name, cycle_cnt_b, sat(k, 19)); else n_pass++;
      n_checks++; if (cycle_cnt_c !== 4'(sat(k, 14))) $display("FAIL %s run_cnt_c: got %0d want %0d", name, cycle_cnt_c, sat(k, 14)); else n_pass++;
      host_mem_req = 1'($urandom_range(0, 1));
      #1;
      n_checks++; if (host_gnt_a !== 1'b0 || mem_sel_core_a !== 1'b1) $display("FAIL %s run_arb: gnt=%b mem_sel=%b want 0/1", name, host_gnt_a, mem_sel_core_a); else n_pass++;
      step();
    end
    core_done = 1'b1;
    n_checks++; if (cycle_cnt_a !== 16'(t)) $display("FAIL %s last_cnt: got %0d want %0d", name, cycle_cnt_a, t); else n_pass++;
    step();
    n_checks++; if (done_a !== 1'b1 || timeout_a !== 1'b0) $display("FAIL %s end_a: done=%b timeout=%b want 1/0", name, done_a, timeout_a); else n_pass++;
    n_checks++; if (cycle_cnt_a !== 16'(t)) $display("FAIL %s end_cnt_a: got %0d want %0d", name, cycle_cnt_a, t); else n_pass++;
    n_checks++; if (busy_a !== 1'b0 || core_reset_a !== 1'b1 || mem_sel_core_a !== 1'b0) $display("FAIL %s end_ctrl: busy=%b core_reset=%b mem_sel=%b want 0/1/0", name, busy_a, core_reset_a, mem_sel_core_a); else n_pass++;
    n_checks++; if (done_b !== (t <= 19) || timeout_b !== (t > 19)) $display("FAIL %s end_b: done=%b timeout=%b want %b/%b", name, done_b, timeout_b, (t <= 19), (t > 19)); else n_pass++;
    n_checks++; if (cycle_cnt_b !== 16'(sat(t, 19))) $display("FAIL %s end_cnt_b: got %0d want %0d", name, cycle_cnt_b, sat(t, 19)); else n_pass++;
    n_checks++; if (done_c !== (t <= 14) || timeout_c !== (t > 14)) $display("FAIL %s end_c: done=%b timeout=%b want %b/%b", name, done_c, timeout_c, (t <= 14), (t > 14)); else n_pass++;
    n_checks++; if (cycle_cnt_c !== 4'(sat(t, 14))) $display("FAIL %s end_cnt_c: got %0d want %0d", name, cycle_cnt_c, sat(t, 14)); else n_pass++;
    host_mem_req = 1'b1;
    #1;
    n_checks++; if (host_gnt_a !== 1'b1) $display("FAIL %s done_gnt: got %b want 1", name, host_gnt_a); else n_pass++;
    req = 1'b0; core_done = 1'b0;
    step();
    n_checks++; if (done_a !== 1'b0 || done_b !== 1'b0 || timeout_b !== 1'b0 || timeout_c !== 1'b0) $display("FAIL %s flags_clear: a=%b b=%b%b c=%b want 0", name, done_a, done_b, timeout_b, timeout_c); else n_pass++;
    n_checks++; if (cycle_cnt_a !== 16'(t)) $display("FAIL %s cnt_kept: got %0d want %0d", name, cycle_cnt_a, t); else n_pass++;
    $display("%s: prog=%0d t=%0d hold=%0d drop=%0d start_pc=%h cnt_a=%0d cnt_b=%0d cnt_c=%0d", name, sel, t, hold, drop_req, start_pc_a, cycle_cnt_a, cycle_cnt_b, cycle_cnt_c);
  endtask

  task automatic test_normal();
    do_run("normal", 2, 36, 0, 1'b0);
  endtask

  task automatic test_timeout();
    do_run("timeout", 1, 40, 0, 1'b0);
  endtask

  task automatic test_race();
    do_run("race_b", 0, 19, 0, 1'b0);
    do_run("race_c", 3, 14, 0, 1'b0);
  endtask

  task automatic test_arbitration();
    do_run("arbitration", 1, 5, 3, 1'b0);
  endtask

  task automatic test_req_drop();
    do_run("req_drop", 3, 8, 0, 1'b1);
  endtask

  task automatic test_reset_midrun();
    prog_sel = 2'd3; req = 1'b1; host_mem_req = 1'b0; core_done = 1'b0;
    repeat (8) step();
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (core_reset_a !== 1'b1 || busy_a !== 1'b0) $display("FAIL midrun_reset ctrl: core_reset=%b busy=%b want 1/0", core_reset_a, busy_a); else n_pass++;
    n_checks++; if (cycle_cnt_a !== 16'd0) $display("FAIL midrun_reset cnt: got %0d want 0", cycle_cnt_a); else n_pass++;
    n_checks++; if (start_pc_a !== 12'h000 || mem_sel_core_a !== 1'b0) $display("FAIL midrun_reset pc_sel: pc=%h mem_sel=%b want 000/0", start_pc_a, mem_sel_core_a); else n_pass++;
    req = 1'b0;
    reset = 1'b1;
    step();
    n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL midrun_reset idle: busy=%b done=%b want 0/0", busy_a, done_a); else n_pass++;
    $display("reset_midrun: run abandoned, cnt_a=%0d", cycle_cnt_a);
  endtask

  task automatic test_random();
    int sel, t, hold;
    bit drop;
    for (int n = 0; n < 12; n++) begin
      sel  = $urandom_range(0, 3);
      t    = $urandom_range(0, 30);
      hold = $urandom_range(0, 2);
      drop = (t <= 14) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_run("random", sel, t, hold, drop);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_race();
    test_arbitration();
    test_req_drop();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
